// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants for the seven-segment IO display controller:
//                register select codes, reset values and the hex-to-segment
//                lookup table (active-high, bit order {g,f,e,d,c,b,a}).
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Register select codes presented on io_sel
    localparam logic [1:0] SEL_VALUE = 2'd0;
    localparam logic [1:0] SEL_EN    = 2'd1;
    localparam logic [1:0] SEL_DP    = 2'd2;
    localparam logic [1:0] SEL_BLINK = 2'd3;

    // Reset values
    localparam logic [31:0] VALUE_RST = 32'h0000_0000;
    localparam logic [7:0]  EN_RST    = 8'hFF;
    localparam logic [7:0]  DP_RST    = 8'h00;
    localparam logic [7:0]  BLINK_RST = 8'h00;

    // Blanked drive levels (both cathodes and anodes are active-low)
    localparam logic [7:0]  SEG_OFF   = 8'hFF;
    localparam logic [7:0]  AN_OFF    = 8'hFF;

    // Hex digit to active-high segments {g,f,e,d,c,b,a}
    localparam logic [6:0] HEX7_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_hex_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_hex_decoder
//  Description : Combinational 4-bit hex value to 7-segment pattern decoder.
//  Revision    : 1.0 - initial release
//  Ports       : nibble_i [3:0]  hex digit to decode
//                seg_o    [6:0]  active-high segments {g,f,e,d,c,b,a}
// ============================================================================
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX7_TABLE[nibble_i];

endmodule : seg7_hex_decoder
`default_nettype wire

// File: rtl/seg7_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_io_ctrl
//  Description : Memory-mapped 8-digit seven-segment display controller.
//                The CPU writes live VALUE / EN / DP (/ BLINK) registers;
//                these are copied to shadow registers when the scan wraps to
//                digit 0 so a frame is never shown half old, half new.
//                One digit is driven every SCAN_DIV clocks.
//  Revision    : 1.0 - initial release
//  Options     : SEG7_BLINK_EN - adds BLINK_MASK register (sel 3) and a
//                64-frame blink phase; when undefined sel 3 reads 0 and
//                writes to it are dropped.
//  Ports       : clock          CPU clock
//                reset          synchronous, active-high
//                io_we          one-clock write strobe
//                io_sel   [1:0] register select (VALUE/EN/DP/BLINK)
//                io_wdata [31:0] write data
//                io_rdata [31:0] combinational readback of live register
//                seg_out  [7:0] active-low cathodes {dp,g,f,e,d,c,b,a}
//                an_out   [7:0] active-low anodes, bit i = digit i
// ============================================================================
module seg7_io_ctrl
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV   = 23000,
    parameter int NUM_DIGITS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_we,
    input  logic [1:0]  io_sel,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    output logic [7:0]  seg_out,
    output logic [7:0]  an_out
);

    localparam int             CNT_W      = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0]     DIGIT_LAST = 3'(NUM_DIGITS - 1);

    // Live registers (CPU visible)
    logic [31:0] value_q, value_d;
    logic [7:0]  en_q,    en_d;
    logic [7:0]  dp_q,    dp_d;

    // Shadow registers (what the current frame displays)
    logic [31:0] sh_value_q;
    logic [7:0]  sh_en_q;
    logic [7:0]  sh_dp_q;

    // Scan state
    logic [CNT_W-1:0] div_q, div_d;
    logic [2:0]       digit_q, digit_d;

    // Registered outputs
    logic [7:0] seg_q, seg_d;
    logic [7:0] an_q,  an_d;

    logic       w_tc;
    logic       w_wrap;
    logic [3:0] w_nibble;
    logic [6:0] w_hex;
    logic       w_on;

`ifdef SEG7_BLINK_EN
    logic [7:0] blink_q, blink_d;
    logic [7:0] sh_blink_q;
    logic [5:0] frame_q, frame_d;
    logic       phase_q, phase_d;
`endif

    // ------------------------------------------------------------------
    // Register writes
    // ------------------------------------------------------------------
    always_comb begin
        value_d = value_q;
        en_d    = en_q;
        dp_d    = dp_q;
        if (io_we) begin
            case (io_sel)
                SEL_VALUE: value_d = io_wdata;
                SEL_EN:    en_d    = io_wdata[7:0];
                SEL_DP:    dp_d    = io_wdata[7:0];
                default:   ;
            endcase
        end
    end

`ifdef SEG7_BLINK_EN
    always_comb begin
        blink_d = blink_q;
        if (io_we && (io_sel == SEL_BLINK)) begin
            blink_d = io_wdata[7:0];
        end
    end
`endif

    // ------------------------------------------------------------------
    // Readback (live registers, zero-extended)
    // ------------------------------------------------------------------
    always_comb begin
        io_rdata = 32'd0;
        case (io_sel)
            SEL_VALUE: io_rdata = value_q;
            SEL_EN:    io_rdata = {24'd0, en_q};
            SEL_DP:    io_rdata = {24'd0, dp_q};
`ifdef SEG7_BLINK_EN
            SEL_BLINK: io_rdata = {24'd0, blink_q};
`endif
            default:   io_rdata = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Scan divider and digit counter
    // ------------------------------------------------------------------
    assign w_tc   = (div_q == CNT_LAST);
    assign w_wrap = w_tc && (digit_q == DIGIT_LAST);

    always_comb begin
        div_d   = w_tc ? '0 : div_q + CNT_W'(1);
        digit_d = digit_q;
        if (w_wrap) begin
            digit_d = 3'd0;
        end else if (w_tc) begin
            digit_d = digit_q + 3'd1;
        end
    end

`ifdef SEG7_BLINK_EN
    // Phase flips on the wrap that ends every 64th frame
    always_comb begin
        frame_d = frame_q;
        phase_d = phase_q;
        if (w_wrap) begin
            frame_d = frame_q + 6'd1;
            if (frame_q == 6'd63) begin
                phase_d = ~phase_q;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output pattern for the digit currently selected
    // ------------------------------------------------------------------
    assign w_nibble = sh_value_q[{digit_q, 2'b00} +: 4];

    seg7_hex_decoder u_hex_decoder (
        .nibble_i (w_nibble),
        .seg_o    (w_hex)
    );

    always_comb begin
        w_on = sh_en_q[digit_q];
`ifdef SEG7_BLINK_EN
        if (phase_q && sh_blink_q[digit_q]) begin
            w_on = 1'b0;
        end
`endif
    end

    always_comb begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if (w_on) begin
            seg_d = {~sh_dp_q[digit_q], ~w_hex};
            an_d  = ~(8'h01 << digit_q);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            value_q    <= VALUE_RST;
            en_q       <= EN_RST;
            dp_q       <= DP_RST;
            sh_value_q <= VALUE_RST;
            sh_en_q    <= EN_RST;
            sh_dp_q    <= DP_RST;
            div_q      <= '0;
            digit_q    <= 3'd0;
            seg_q      <= SEG_OFF;
            an_q       <= AN_OFF;
        end else begin
            value_q <= value_d;
            en_q    <= en_d;
            dp_q    <= dp_d;
            // Latch the pre-write live values: a write on the wrap cycle
            // belongs to the following frame.
            if (w_wrap) begin
                sh_value_q <= value_q;
                sh_en_q    <= en_q;
                sh_dp_q    <= dp_q;
            end
            div_q   <= div_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

`ifdef SEG7_BLINK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_q    <= BLINK_RST;
            sh_blink_q <= BLINK_RST;
            frame_q    <= 6'd0;
            phase_q    <= 1'b0;
        end else begin
            blink_q <= blink_d;
            if (w_wrap) begin
                sh_blink_q <= blink_q;
            end
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end
`endif

    assign seg_out = seg_q;
    assign an_out  = an_q;

endmodule : seg7_io_ctrl
`default_nettype wire
